// File: rtl/ffa_subfilter_if.sv
// Sample/coefficient inputs and result outputs of one fast-FIR sub-filter.
// The master drives samples and coefficients; the sub-filter is the slave.
interface ffa_subfilter_if #(
    parameter int NR_TAPS = 16,
    parameter int DWIDTH  = 16,
    parameter int GUARD   = 4
);
    localparam int CWIDTH = NR_TAPS * DWIDTH;
    localparam int AWIDTH = 2 * DWIDTH + GUARD;

    logic                     in_valid;
    logic signed [DWIDTH-1:0] data_in;
    logic [CWIDTH-1:0]        h_in;
    logic                     coef_load;
    logic                     out_valid;
    logic signed [AWIDTH-1:0] data_out;
    logic                     primed;

    modport master (
        output in_valid, data_in, h_in, coef_load,
        input  out_valid, data_out, primed
    );

    modport slave (
        input  in_valid, data_in, h_in, coef_load,
        output out_valid, data_out, primed
    );
endinterface

// File: rtl/ffa_subfilter.sv
// Transposed-form FIR sub-filter of the 2-parallel fast-FIR, full-precision accumulation.
// Optional coefficient shadow register: define SUBFILT_COEF_LATCH_EN.
module ffa_subfilter #(
    parameter int NR_TAPS = 16,
    parameter int DWIDTH  = 16,
    parameter int GUARD   = 4,
    parameter int CWIDTH  = NR_TAPS * DWIDTH,
    parameter int AWIDTH  = 2 * DWIDTH + GUARD
) (
    input logic            clk,
    input logic            rst,
    ffa_subfilter_if.slave bus
);
    localparam int PWIDTH = 2 * DWIDTH;
    localparam int CNT_W  = $clog2(NR_TAPS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NR_TAPS);

    logic [CWIDTH-1:0] coef_use;

`ifdef SUBFILT_COEF_LATCH_EN
    logic [CWIDTH-1:0] coef_q;
    logic [CWIDTH-1:0] coef_d;

    // A sample arriving with coef_load still multiplies by the old shadow value.
    always_comb begin
        coef_d = coef_q;
        if (bus.coef_load) begin
            coef_d = bus.h_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coef_q <= '0;
        end else begin
            coef_q <= coef_d;
        end
    end

    assign coef_use = coef_q;
`else
    logic unused_coef_load;

    assign unused_coef_load = bus.coef_load;
    assign coef_use         = bus.h_in;
`endif

    logic signed [AWIDTH-1:0] prod [NR_TAPS];

    // Tap 0 sits in the most significant coefficient slot.
    always_comb begin
        logic signed [PWIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < NR_TAPS; i++) begin
            p       = $signed(bus.data_in) * $signed(coef_use[(NR_TAPS-1-i)*DWIDTH +: DWIDTH]);
            prod[i] = {{(AWIDTH-PWIDTH){p[PWIDTH-1]}}, p};
        end
    end

    logic signed [AWIDTH-1:0] acc_q [NR_TAPS];
    logic signed [AWIDTH-1:0] acc_d [NR_TAPS];

    always_comb begin
        acc_d = acc_q;
        if (bus.in_valid) begin
            for (int i = 0; i < NR_TAPS - 1; i++) begin
                acc_d[i] = prod[i] + acc_q[i+1];
            end
            acc_d[NR_TAPS-1] = prod[NR_TAPS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_TAPS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_valid_q;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.in_valid && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= bus.in_valid;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = acc_q[0];
    assign bus.primed    = (cnt_q == CNT_FULL);
endmodule

// File: tb/tb_ffa_subfilter.sv
// Self-checking bench for ffa_subfilter: directed vectors plus randomized traffic
// against a per-sample history model.
module tb_ffa_subfilter;
    localparam int NT = 16;
    localparam int DW = 16;
    localparam int GD = 4;
    localparam int CW = NT * DW;
    localparam int AW = 2 * DW + GD;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ffa_subfilter_if #(.NR_TAPS(NT), .DWIDTH(DW), .GUARD(GD)) bus ();

    ffa_subfilter #(.NR_TAPS(NT), .DWIDTH(DW), .GUARD(GD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: every accepted sample remembers the coefficient set it was multiplied by.
    int            xs[$];
    logic [CW-1:0] cs[$];
    logic [CW-1:0] shadow;
    longint        exp_out;
    bit            exp_ov;
    int            n_acc;

    typedef struct {
        bit     v;
        int     x;
        longint e_out;
        bit     e_ov;
        bit     e_pr;
    } vec_t;

    vec_t vec[21];

    function automatic logic [CW-1:0] all_taps(input int val);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < NT; i++) r[(NT-1-i)*DW +: DW] = DW'(val);
        return r;
    endfunction

    function automatic logic [CW-1:0] ramp_taps();
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < NT; i++) r[(NT-1-i)*DW +: DW] = DW'(i + 1);
        return r;
    endfunction

    function automatic logic [CW-1:0] rand_taps();
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < NT; i++) r[(NT-1-i)*DW +: DW] = DW'($urandom_range(0, 65535));
        return r;
    endfunction

    function automatic longint tap(input logic [CW-1:0] h, input int i);
        logic signed [DW-1:0] t;
        t = h[(NT-1-i)*DW +: DW];
        return longint'(t);
    endfunction

    function automatic longint model_y();
        longint s;
        int     k;
        s = 0;
        for (int i = 0; i < NT; i++) begin
            if (i < xs.size()) begin
                k = xs.size() - 1 - i;
                s += longint'(xs[k]) * tap(cs[k], i);
            end
        end
        return s;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int x, input logic [CW-1:0] h, input bit cl);
        logic [CW-1:0] use_c;
        rst           = r;
        bus.in_valid  = v;
        bus.data_in   = DW'(x);
        bus.h_in      = h;
        bus.coef_load = cl;
        @(posedge clk);
        if (r) begin
            xs.delete();
            cs.delete();
            shadow  = '0;
            exp_out = 0;
            exp_ov  = 0;
            n_acc   = 0;
        end else begin
`ifdef SUBFILT_COEF_LATCH_EN
            use_c = shadow;
            if (cl) shadow = h;
`else
            use_c = h;
`endif
            exp_ov = v;
            if (v) begin
                xs.push_back(x);
                cs.push_back(use_c);
                if (xs.size() > NT) begin
                    void'(xs.pop_front());
                    void'(cs.pop_front());
                end
                n_acc++;
                exp_out = model_y();
            end
        end
        #1;
        chk("out_valid", longint'(bus.out_valid), longint'(exp_ov));
        chk("data_out", longint'($signed(bus.data_out)), exp_out);
        chk("primed", longint'(bus.primed), longint'(n_acc >= NT));
    endtask

    task automatic restart(input logic [CW-1:0] h);
        cycle(1, 0, 0, h, 0);
        cycle(0, 0, 0, h, 1);
    endtask

    initial begin
        logic [CW-1:0] h;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.h_in      = '0;
        bus.coef_load = 1'b0;
        shadow        = '0;
        exp_out       = 0;
        exp_ov        = 0;
        n_acc         = 0;

        for (int k = 0; k < 21; k++) begin
            vec[k].v     = 1'b1;
            vec[k].x     = (k == 0) ? 1 : 0;
            vec[k].e_out = (k < NT) ? longint'(k + 1) : 0;
            vec[k].e_ov  = 1'b1;
            vec[k].e_pr  = (k >= NT - 1);
        end

        // Reset state
        cycle(1, 0, 0, '0, 0);
        cycle(1, 1, 9, ramp_taps(), 1);
        chk("reset_data_out", longint'($signed(bus.data_out)), 0);
        chk("reset_out_valid", longint'(bus.out_valid), 0);

        // Impulse response, continuous
        h = ramp_taps();
        restart(h);
        for (int k = 0; k < 21; k++) begin
            cycle(0, vec[k].v, vec[k].x, h, 0);
            chk("tbl_out", longint'($signed(bus.data_out)), vec[k].e_out);
            chk("tbl_ov", longint'(bus.out_valid), longint'(vec[k].e_ov));
            chk("tbl_primed", longint'(bus.primed), longint'(vec[k].e_pr));
        end

        // Impulse response with 3-cycle gaps
        restart(h);
        for (int k = 0; k < 18; k++) begin
            cycle(0, 1, (k == 0) ? 1 : 0, h, 0);
            chk("stall_out", longint'($signed(bus.data_out)), (k < NT) ? longint'(k + 1) : 0);
            for (int g = 0; g < 3; g++) begin
                cycle(0, 0, 12345, h, 0);
                chk("stall_hold", longint'($signed(bus.data_out)), (k < NT) ? longint'(k + 1) : 0);
            end
        end

        // Extreme values
        h = all_taps(-32768);
        restart(h);
        for (int k = 0; k < NT; k++) cycle(0, 1, -32768, h, 0);
        chk("extreme_out", longint'($signed(bus.data_out)), 64'sd17179869184);
        chk("extreme_primed", longint'(bus.primed), 1);

        // Mid-stream reset
        h = all_taps(1);
        restart(h);
        for (int k = 0; k < 8; k++) cycle(0, 1, 100, h, 0);
        chk("pre_rst_out", longint'($signed(bus.data_out)), 800);
        cycle(1, 0, 0, h, 0);
        chk("rst_ov", longint'(bus.out_valid), 0);
        chk("rst_primed", longint'(bus.primed), 0);
        cycle(0, 0, 0, h, 1);
        cycle(0, 1, 5, h, 0);
        chk("post_rst_out", longint'($signed(bus.data_out)), 5);
        chk("post_rst_primed", longint'(bus.primed), 0);

        // rst and in_valid on the same edge
        h = ramp_taps();
        cycle(1, 1, 7, h, 0);
        chk("rst_sample_ov", longint'(bus.out_valid), 0);
        cycle(0, 0, 0, h, 1);
        cycle(0, 1, 3, h, 0);
        chk("after_drop_out", longint'($signed(bus.data_out)), 3);

`ifdef SUBFILT_COEF_LATCH_EN
        // Shadow load coincident with a sample
        h = all_taps(2);
        restart(h);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, all_taps(9), 0);
        chk("latch_old", longint'($signed(bus.data_out)), 8);
        cycle(0, 1, 1, all_taps(3), 1);
        chk("latch_same_edge", longint'($signed(bus.data_out)), 10);
        cycle(0, 1, 1, all_taps(5), 0);
        chk("latch_next", longint'($signed(bus.data_out)), 13);
`endif

        // Randomized traffic
        h = rand_taps();
        restart(h);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) h = rand_taps();
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 65535)) - 32768, h, ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
